// File: rtl/mule_sched_pkg.sv
// mule_sched shared types: MULE func codes,
// scheduler state encoding, register index width.
package mule_sched_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    MULE_FUNC_MUL    = 2'd0,
    MULE_FUNC_MULH   = 2'd1,
    MULE_FUNC_MULHSU = 2'd2,
    MULE_FUNC_MULHU  = 2'd3
  } mule_func_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_WB,
    S_DRAIN
  } mule_state_e;

endpackage

// File: rtl/mule_rr_arb2.sv
// Two-requester round-robin arbiter.
// req_i/en_i in, one-hot gnt_o out; ptr flips on contended grant.
module mule_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;
  logic both;

  assign both = &req_i;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (both) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
        ptr_d = ~ptr_q;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mule_sched.sv
// Scheduler for the shared MULE multiplier: arbitrates
// pipe0/pipe1, drives unit handshake, writeback, scoreboard, stats.
module mule_sched
  import mule_sched_pkg::*;
#(
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 p0_valid_i,
  input  logic [31:0]          p0_ra_i,
  input  logic [31:0]          p0_rb_i,
  input  logic [REG_IDX_W-1:0] p0_rd_i,
  input  logic [1:0]           p0_func_i,
  output logic                 p0_accept_o,
  input  logic                 p1_valid_i,
  input  logic [31:0]          p1_ra_i,
  input  logic [31:0]          p1_rb_i,
  input  logic [REG_IDX_W-1:0] p1_rd_i,
  input  logic [1:0]           p1_func_i,
  output logic                 p1_accept_o,
  output logic                 unit_valid_o,
  output logic [31:0]          unit_ra_o,
  output logic [31:0]          unit_rb_o,
  output logic [1:0]           unit_func_o,
  input  logic                 unit_accept_i,
  input  logic                 unit_done_i,
  input  logic [31:0]          unit_result_i,
  output logic                 wb_valid_o,
  output logic [REG_IDX_W-1:0] wb_rd_o,
  output logic [31:0]          wb_value_o,
  input  logic                 wb_accept_i,
  output logic                 pending_valid_o,
  output logic [REG_IDX_W-1:0] pending_rd_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [LAT_W-1:0]     last_latency_o,
  output logic [15:0]          op_count_o
);

  localparam int TO_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  mule_state_e          st_q, st_d;
  logic [31:0]          ra_q, ra_d;
  logic [31:0]          rb_q, rb_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  mule_func_e           fn_q, fn_d;
  logic [31:0]          res_q, res_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [LAT_W-1:0]     last_q, last_d;
  logic [TO_W-1:0]      bcnt_q, bcnt_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic                 uv_q, wv_q, busy_q, pv_q;
  logic [REG_IDX_W-1:0] prd_q;
  logic                 pend_d;
  logic                 go;
  logic [1:0]           gnt;

  assign go = rst && (st_q == S_IDLE) && !flush_i;

  mule_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({p1_valid_i, p0_valid_i}),
    .en_i  (go),
    .gnt_o (gnt)
  );

  assign p0_accept_o = gnt[0];
  assign p1_accept_o = gnt[1];

  always_comb begin
    st_d   = st_q;
    ra_d   = ra_q;
    rb_d   = rb_q;
    rd_d   = rd_q;
    fn_d   = fn_q;
    res_d  = res_q;
    last_d = last_q;
    bcnt_d = bcnt_q;
    cnt_d  = cnt_q;
    to_d   = to_q;
    lat_d  = lat_q;
    if (st_q != S_IDLE && lat_q != '1) begin
      lat_d = lat_q + 1'b1;
    end
    unique case (st_q)
      S_IDLE: begin
        if (|gnt) begin
          st_d  = S_ISSUE;
          ra_d  = gnt[1] ? p1_ra_i : p0_ra_i;
          rb_d  = gnt[1] ? p1_rb_i : p0_rb_i;
          rd_d  = gnt[1] ? p1_rd_i : p0_rd_i;
          fn_d  = mule_func_e'(gnt[1] ? p1_func_i
                                      : p0_func_i);
          lat_d = '0;
        end
      end
      S_ISSUE: begin
        if (flush_i) begin
          st_d = unit_accept_i ? S_DRAIN : S_IDLE;
        end else if (unit_accept_i) begin
          st_d   = S_BUSY;
          bcnt_d = '0;
        end
      end
      S_BUSY: begin
        bcnt_d = bcnt_q + 1'b1;
        if (flush_i) begin
          st_d = unit_done_i ? S_IDLE : S_DRAIN;
        end else if (unit_done_i) begin
          if (rd_q != '0) begin
            st_d  = S_WB;
            res_d = unit_result_i;
          end else begin
            st_d = S_IDLE;
          end
        end else if (TIMEOUT != 0 &&
                     bcnt_d == TO_W'(TIMEOUT)) begin
          st_d = S_DRAIN;
          to_d = 1'b1;
        end
      end
      S_WB: begin
        if (flush_i) begin
          st_d = S_IDLE;
        end else if (wb_accept_i) begin
          st_d   = S_IDLE;
          cnt_d  = cnt_q + 16'd1;
          last_d = (lat_q == '1) ? lat_q
                                 : lat_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (unit_done_i) begin
          st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign pend_d = (st_d == S_ISSUE || st_d == S_BUSY ||
                   st_d == S_WB) && (rd_d != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      ra_q   <= '0;
      rb_q   <= '0;
      rd_q   <= '0;
      fn_q   <= MULE_FUNC_MUL;
      res_q  <= '0;
      lat_q  <= '0;
      last_q <= '0;
      bcnt_q <= '0;
      cnt_q  <= '0;
      to_q   <= 1'b0;
      uv_q   <= 1'b0;
      wv_q   <= 1'b0;
      busy_q <= 1'b0;
      pv_q   <= 1'b0;
      prd_q  <= '0;
    end else begin
      st_q   <= st_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      rd_q   <= rd_d;
      fn_q   <= fn_d;
      res_q  <= res_d;
      lat_q  <= lat_d;
      last_q <= last_d;
      bcnt_q <= bcnt_d;
      cnt_q  <= cnt_d;
      to_q   <= to_d;
      uv_q   <= (st_d == S_ISSUE);
      wv_q   <= (st_d == S_WB);
      busy_q <= (st_d != S_IDLE);
      pv_q   <= pend_d;
      prd_q  <= pend_d ? rd_d : '0;
    end
  end

  assign unit_valid_o    = uv_q;
  assign unit_ra_o       = ra_q;
  assign unit_rb_o       = rb_q;
  assign unit_func_o     = fn_q;
  assign wb_valid_o      = wv_q;
  assign wb_rd_o         = rd_q;
  assign wb_value_o      = res_q;
  assign pending_valid_o = pv_q;
  assign pending_rd_o    = prd_q;
  assign busy_o          = busy_q;
  assign timeout_o       = to_q;
  assign last_latency_o  = last_q;
  assign op_count_o      = cnt_q;

endmodule

// File: tb/tb_mule_sched.sv
// Self-checking bench for mule_sched: per-cycle
// behavioural model plus directed literal checks.
module tb_mule_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        p0_valid_i, p1_valid_i;
  logic [31:0] p0_ra_i, p0_rb_i, p1_ra_i, p1_rb_i;
  logic [4:0]  p0_rd_i, p1_rd_i;
  logic [1:0]  p0_func_i, p1_func_i;
  logic        p0_accept_o, p1_accept_o;
  logic        unit_valid_o;
  logic [31:0] unit_ra_o, unit_rb_o;
  logic [1:0]  unit_func_o;
  logic        unit_accept_i, unit_done_i;
  logic [31:0] unit_result_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        wb_accept_i;
  logic        pending_valid_o;
  logic [4:0]  pending_rd_o;
  logic        busy_o, timeout_o;
  logic [7:0]  last_latency_o;
  logic [15:0] op_count_o;

  always #5 clk = ~clk;

  mule_sched #(.LAT_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .p0_valid_i(p0_valid_i), .p0_ra_i(p0_ra_i),
    .p0_rb_i(p0_rb_i), .p0_rd_i(p0_rd_i),
    .p0_func_i(p0_func_i), .p0_accept_o(p0_accept_o),
    .p1_valid_i(p1_valid_i), .p1_ra_i(p1_ra_i),
    .p1_rb_i(p1_rb_i), .p1_rd_i(p1_rd_i),
    .p1_func_i(p1_func_i), .p1_accept_o(p1_accept_o),
    .unit_valid_o(unit_valid_o), .unit_ra_o(unit_ra_o),
    .unit_rb_o(unit_rb_o), .unit_func_o(unit_func_o),
    .unit_accept_i(unit_accept_i),
    .unit_done_i(unit_done_i),
    .unit_result_i(unit_result_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
    .wb_value_o(wb_value_o), .wb_accept_i(wb_accept_i),
    .pending_valid_o(pending_valid_o),
    .pending_rd_o(pending_rd_o),
    .busy_o(busy_o), .timeout_o(timeout_o),
    .last_latency_o(last_latency_o),
    .op_count_o(op_count_o)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  // Model: op phase 0=none 1=offered to unit
  // 2=unit computing 3=awaiting regfile 4=discarding
  int          ph = 0;
  int          ncyc = 0;
  int          bcy = 0;
  bit          synced = 0;
  logic [31:0] m_ra = 0, m_rb = 0, m_res = 0;
  logic [4:0]  m_rd = 0;
  logic [1:0]  m_fn = 0;
  logic        m_to = 0, m_ptr = 0;
  logic [7:0]  m_last = 0;
  logic [15:0] m_cnt = 0;

  task automatic model_cycle();
    logic a0, a1, pend;
    a0 = rst && ph == 0 && !flush_i && p0_valid_i &&
         (!p1_valid_i || !m_ptr);
    a1 = rst && ph == 0 && !flush_i && p1_valid_i &&
         (!p0_valid_i || m_ptr);
    pend = (ph >= 1 && ph <= 3) && m_rd != 0;
    if (synced) begin
      chk("p0_accept", p0_accept_o, a0);
      chk("p1_accept", p1_accept_o, a1);
      chk("unit_valid", unit_valid_o, ph == 1);
      chk("unit_ra", unit_ra_o, m_ra);
      chk("unit_rb", unit_rb_o, m_rb);
      chk("unit_func", unit_func_o, m_fn);
      chk("wb_valid", wb_valid_o, ph == 3);
      chk("wb_rd", wb_rd_o, m_rd);
      chk("wb_value", wb_value_o, m_res);
      chk("pend_valid", pending_valid_o, pend);
      chk("pend_rd", pending_rd_o, pend ? m_rd : 5'd0);
      chk("busy", busy_o, ph != 0);
      chk("timeout", timeout_o, m_to);
      chk("last_lat", last_latency_o, m_last);
      chk("op_count", op_count_o, m_cnt);
    end
    if (!rst) begin
      ph = 0; ncyc = 0; bcy = 0; m_ra = 0; m_rb = 0;
      m_res = 0; m_rd = 0; m_fn = 0; m_to = 0;
      m_ptr = 0; m_last = 0; m_cnt = 0;
      synced = 1;
      return;
    end
    if (ph != 0) ncyc++;
    case (ph)
      0: if (a0 || a1) begin
        m_ra = a1 ? p1_ra_i : p0_ra_i;
        m_rb = a1 ? p1_rb_i : p0_rb_i;
        m_rd = a1 ? p1_rd_i : p0_rd_i;
        m_fn = a1 ? p1_func_i : p0_func_i;
        if (p0_valid_i && p1_valid_i) m_ptr = ~m_ptr;
        ncyc = 0;
        ph = 1;
      end
      1: if (flush_i) ph = unit_accept_i ? 4 : 0;
         else if (unit_accept_i) begin
           ph = 2; bcy = 0;
         end
      2: begin
        bcy++;
        if (flush_i) ph = unit_done_i ? 0 : 4;
        else if (unit_done_i) begin
          if (m_rd != 0) begin
            m_res = unit_result_i; ph = 3;
          end else ph = 0;
        end else if (bcy == 4) begin
          m_to = 1; ph = 4;
        end
      end
      3: if (flush_i) ph = 0;
         else if (wb_accept_i) begin
           m_cnt = m_cnt + 16'd1;
           m_last = (ncyc > 255) ? 8'hff : 8'(ncyc);
           ph = 0;
         end
      4: if (unit_done_i) ph = 0;
      default: ph = 0;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  logic g0, g1, ag0, ag1;

  task automatic cyc(input bit v0, input bit v1,
                     input bit fl, input bit ua,
                     input bit ud, input bit wa,
                     input logic [31:0] res);
    p0_valid_i    = v0;
    p1_valid_i    = v1;
    flush_i       = fl;
    unit_accept_i = ua;
    unit_done_i   = ud;
    wb_accept_i   = wa;
    unit_result_i = res;
    #1;
    g0 = p0_accept_o;
    g1 = p1_accept_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  task automatic issue(input bit v0, input bit v1,
                       input int iw, input int bc,
                       input logic [31:0] res);
    cyc(v0, v1, 0, 0, 0, 0, 32'd0);
    ag0 = g0;
    ag1 = g1;
    for (int i = 0; i < iw; i++) idle();
    cyc(0, 0, 0, 1, 0, 0, 32'd0);
    for (int i = 1; i < bc; i++) idle();
    cyc(0, 0, 0, 0, 1, 0, res);
  endtask

  task automatic wb(input int ww, input bit hv);
    for (int i = 0; i < ww; i++) begin
      cyc(hv, hv, 0, 0, 0, 0, 32'd0);
      chk("stall_wbv", wb_valid_o, 1);
      chk("stall_acc", {g1, g0}, 2'b00);
    end
    cyc(0, 0, 0, 0, 0, 1, 32'd0);
  endtask

  initial begin
    rst = 0; flush_i = 0;
    p0_valid_i = 0; p1_valid_i = 0;
    p0_ra_i = 0; p0_rb_i = 0; p0_rd_i = 0; p0_func_i = 0;
    p1_ra_i = 0; p1_rb_i = 0; p1_rd_i = 0; p1_func_i = 0;
    unit_accept_i = 0; unit_done_i = 0;
    unit_result_i = 0; wb_accept_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", op_count_o, 0);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_to", timeout_o, 0);

    // single pipe0 MUL 7*9 -> rd13
    p0_ra_i = 7; p0_rb_i = 9; p0_rd_i = 13;
    p0_func_i = 2'd0;
    p1_ra_i = 4; p1_rb_i = 5; p1_rd_i = 12;
    p1_func_i = 2'd3;
    issue(1, 0, 1, 3, p0_ra_i * p0_rb_i);
    chk("t1_grant", {ag1, ag0}, 2'b01);
    chk("t1_wbv", wb_valid_o, 1);
    chk("t1_wbrd", wb_rd_o, 13);
    chk("t1_wbval", wb_value_o, 63);
    chk("t1_pend", pending_rd_o, 13);
    wb(0, 0);
    chk("t1_cnt", op_count_o, 1);
    chk("t1_lat", last_latency_o, 6);

    // contention: grants alternate 0,1,0,1
    p0_rd_i = 12; p0_ra_i = 3; p0_rb_i = 4;
    p1_rd_i = 13;
    for (int i = 0; i < 4; i++) begin
      issue(1, 1, 0, 1, (i % 2 == 0) ? 32'd12 : 32'd20);
      chk("rr_grant", {ag1, ag0},
          (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_wbrd", wb_rd_o, (i % 2 == 0) ? 12 : 13);
      wb(0, 0);
    end
    chk("rr_cnt", op_count_o, 5);

    // rd=0: no writeback
    p0_rd_i = 0;
    issue(1, 0, 0, 2, 32'd99);
    chk("rd0_busy", busy_o, 0);
    chk("rd0_wbv", wb_valid_o, 0);
    chk("rd0_cnt", op_count_o, 5);

    // flush in BUSY, result discarded in DRAIN
    p0_rd_i = 9;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle();
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("fl_drain_busy", busy_o, 1);
    chk("fl_drain_pend", pending_valid_o, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'hDEAD);
    chk("fl_busy_drop", busy_o, 0);
    chk("fl_wbv", wb_valid_o, 0);
    idle();
    chk("fl_cnt", op_count_o, 5);

    // flush in ISSUE, without and with unit accept
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("fli_uv", unit_valid_o, 0);
    chk("fli_busy", busy_o, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("flia_busy", busy_o, 1);
    cyc(0, 0, 0, 0, 1, 0, 32'h1);
    // flush with done in BUSY
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 32'h2);
    chk("fld_busy", busy_o, 0);
    chk("fld_wbv", wb_valid_o, 0);
    // flush in WB
    issue(1, 0, 0, 1, 32'h3);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("flw_cnt", op_count_o, 5);
    chk("flw_busy", busy_o, 0);
    // flush blocks accept in IDLE
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("fl_idle_acc", g0, 0);
    chk("fl_idle_busy", busy_o, 0);

    // 10-cycle writeback stall
    p0_rd_i = 7;
    issue(1, 0, 0, 2, 32'h77);
    wb(10, 1);
    chk("st_lat", last_latency_o, 14);
    chk("st_cnt", op_count_o, 6);

    // timeout after 4 BUSY cycles
    p0_rd_i = 5;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (3) idle();
    chk("to_early", timeout_o, 0);
    idle();
    chk("to_set", timeout_o, 1);
    chk("to_pend", pending_valid_o, 0);
    repeat (2) idle();
    chk("to_drain", busy_o, 1);
    cyc(0, 0, 0, 0, 1, 0, 32'h5);
    chk("to_idle", busy_o, 0);
    chk("to_sticky", timeout_o, 1);

    // reset mid-BUSY
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle();
    rst = 0;
    idle();
    chk("mr_busy", busy_o, 0);
    chk("mr_to", timeout_o, 0);
    chk("mr_cnt", op_count_o, 0);
    chk("mr_lat", last_latency_o, 0);
    chk("mr_ra", unit_ra_o, 0);
    chk("mr_pend", pending_valid_o, 0);
    rst = 1;
    repeat (2) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
